// File: rtl/i2c_reg_arbiter_if.sv
// Host-side request/grant port onto the shared register bank; held request, one-cycle grant.
// Read data returns RD_LAT cycles after the grant, qualified by a one-cycle rvalid.
interface i2c_reg_arbiter_if;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       gnt;
    logic [7:0] rdata;
    logic       rvalid;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdata, rvalid
    );
endinterface

// File: rtl/i2c_reg_arbiter.sv
// Shares the register bank between I2C strobes (async, resynchronised) and a host port; I2C has priority.
// Write 2 clk/access, read 2+RD_LAT; host waits by holding req until gnt, starved at most MAX_I2C_RUN grants.
module i2c_reg_arbiter #(
    parameter int RD_LAT      = 1,
    parameter int MAX_I2C_RUN = 4
) (
    input  logic                 clk,
    input  logic                 rstz,
    input  logic                 i2c_read,
    input  logic                 i2c_write,
    input  logic [7:0]           i2c_addr,
    input  logic [7:0]           i2c_wdata,
    output logic [7:0]           i2c_rdata,
    output logic                 i2c_ovr,
    input  logic                 ovr_clr,
    i2c_reg_arbiter_if.slave     hst,
    output logic [7:0]           rb_addr,
    output logic [7:0]           rb_wdata,
    output logic                 rb_we,
    output logic                 rb_re,
    input  logic [7:0]           rb_rdata
);

    typedef enum logic [1:0] {IDLE, I2C_ACC, HST_ACC, RD_WAIT} state_t;

    localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);
    localparam logic [3:0] RUN_MAX = 4'(MAX_I2C_RUN);

    state_t     state, nxt;
    logic [2:0] rd_sync, wr_sync;
    logic [7:0] addr_s1, addr_s2, wdata_s1, wdata_s2;
    logic [7:0] cap_addr, cap_wdata;
    logic       i2c_pend, pend_wr;
    logic [3:0] run;
    logic [2:0] rd_cnt;
    logic       rd_is_hst;
    logic [7:0] rb_addr_q, rb_wdata_q, hst_rdata_q;
    logic       det_rd, det_wr, det, ovr_set, rd_last;
    logic       gnt, rvalid, i2c_done;

    // Bits [1:0] are the synchroniser, bit [2] is the edge register.
    assign det_rd  = rd_sync[1] & ~rd_sync[2];
    assign det_wr  = wr_sync[1] & ~wr_sync[2];
    assign det     = det_rd | det_wr;
    assign ovr_set = det & ((det_rd & det_wr) | (i2c_pend & (state != I2C_ACC)));
    assign rd_last = (rd_cnt == RD_LAST);

    always_ff @(posedge clk) begin
        if (!rstz) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (i2c_pend && !(hst.req && run == RUN_MAX)) nxt = I2C_ACC;
                else if (hst.req)                             nxt = HST_ACC;
            end
            I2C_ACC: nxt = pend_wr ? IDLE : RD_WAIT;
            HST_ACC: nxt = hst.we  ? IDLE : RD_WAIT;
            RD_WAIT: if (rd_last) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        rb_we    = 1'b0;
        rb_re    = 1'b0;
        rb_addr  = rb_addr_q;
        rb_wdata = rb_wdata_q;
        gnt      = 1'b0;
        rvalid   = 1'b0;
        i2c_done = 1'b0;
        case (state)
            I2C_ACC: begin
                rb_addr  = cap_addr;
                rb_wdata = cap_wdata;
                rb_we    = pend_wr;
                rb_re    = ~pend_wr;
            end
            HST_ACC: begin
                rb_addr  = hst.addr;
                rb_wdata = hst.wdata;
                rb_we    = hst.we;
                rb_re    = ~hst.we;
                gnt      = 1'b1;
            end
            RD_WAIT: begin
                if (rd_last) begin
                    rvalid   = rd_is_hst;
                    i2c_done = ~rd_is_hst;
                end
            end
            default: ;
        endcase
    end

    assign hst.gnt    = gnt;
    assign hst.rvalid = rvalid;
    assign hst.rdata  = rvalid ? rb_rdata : hst_rdata_q;

    always_ff @(posedge clk) begin
        if (!rstz) begin
            rd_sync     <= '0;
            wr_sync     <= '0;
            addr_s1     <= '0;
            addr_s2     <= '0;
            wdata_s1    <= '0;
            wdata_s2    <= '0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            i2c_pend    <= 1'b0;
            pend_wr     <= 1'b0;
            i2c_ovr     <= 1'b0;
            run         <= '0;
            rd_cnt      <= '0;
            rd_is_hst   <= 1'b0;
            rb_addr_q   <= '0;
            rb_wdata_q  <= '0;
            hst_rdata_q <= '0;
            i2c_rdata   <= '0;
        end else begin
            rd_sync  <= {rd_sync[1:0], i2c_read};
            wr_sync  <= {wr_sync[1:0], i2c_write};
            addr_s1  <= i2c_addr;
            addr_s2  <= addr_s1;
            wdata_s1 <= i2c_wdata;
            wdata_s2 <= wdata_s1;

            // A fresh detect beats the clear from the access being issued this cycle.
            if (det) begin
                i2c_pend  <= 1'b1;
                pend_wr   <= det_wr;
                cap_addr  <= addr_s2;
                cap_wdata <= wdata_s2;
            end else if (state == I2C_ACC) begin
                i2c_pend <= 1'b0;
            end

            if (ovr_set)      i2c_ovr <= 1'b1;
            else if (ovr_clr) i2c_ovr <= 1'b0;

            if (!hst.req || state == HST_ACC)          run <= '0;
            else if (state == I2C_ACC && run != RUN_MAX) run <= run + 4'd1;

            if (state != RD_WAIT) rd_cnt <= '0;
            else if (!rd_last)    rd_cnt <= rd_cnt + 3'd1;

            if (state == HST_ACC)      rd_is_hst <= 1'b1;
            else if (state == I2C_ACC) rd_is_hst <= 1'b0;

            rb_addr_q  <= rb_addr;
            rb_wdata_q <= rb_wdata;
            if (rvalid)   hst_rdata_q <= rb_rdata;
            if (i2c_done) i2c_rdata   <= rb_rdata;
        end
    end

endmodule
